// File: rtl/dct_quant_pkg.sv
// dct_quant_pkg: shared tables and types for the quantize/zigzag stage.
// Holds the zigzag scan order, the JPEG luminance quant table (quality 50),
// its 16-fraction-bit reciprocals, the control state enum and the
// rounding-shift helper used by the multiplier.
package dct_quant_pkg;

   // Reciprocals carry this many fraction bits: RECIP = round(2^16 / Q).
   localparam int RECIP_FRAC = 16;

   // Coefficients per 8x8 block.
   localparam int BLK_N = 64;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Raster index (row*8+col) for each zigzag index.
   localparam logic [5:0] ZZ_ORDER [64] = '{
       0,  1,  8, 16,  9,  2,  3, 10,
      17, 24, 32, 25, 18, 11,  4,  5,
      12, 19, 26, 33, 40, 48, 41, 34,
      27, 20, 13,  6,  7, 14, 21, 28,
      35, 42, 49, 56, 57, 50, 43, 36,
      29, 22, 15, 23, 30, 37, 44, 51,
      58, 59, 52, 45, 38, 31, 39, 46,
      53, 60, 61, 54, 47, 55, 62, 63
   };

   // Standard JPEG luminance quantizer, quality 50, raster order.
   localparam logic [7:0] QTAB_LUMA [64] = '{
      16,  11,  10,  16,  24,  40,  51,  61,
      12,  12,  14,  19,  26,  58,  60,  55,
      14,  13,  16,  24,  40,  57,  69,  56,
      14,  17,  22,  29,  51,  87,  80,  62,
      18,  22,  37,  56,  68, 109, 103,  77,
      24,  35,  55,  64,  81, 104, 113,  92,
      49,  64,  78,  87, 103, 121, 120, 101,
      72,  92,  95,  98, 112, 100, 103,  99
   };

   // round(65536 / QTAB_LUMA[r]), raster order.
   localparam logic [16:0] RECIP_LUMA [64] = '{
      4096, 5958, 6554, 4096, 2731, 1638, 1285, 1074,
      5461, 5461, 4681, 3449, 2521, 1130, 1092, 1192,
      4681, 5041, 4096, 2731, 1638, 1150,  950, 1170,
      4681, 3855, 2979, 2260, 1285,  753,  819, 1057,
      3641, 2979, 1771, 1170,  964,  601,  636,  851,
      2731, 1872, 1192, 1024,  809,  630,  580,  712,
      1337, 1024,  840,  753,  636,  542,  546,  649,
       910,  712,  690,  669,  585,  655,  636,  662
   };

   // Total right shift after the multiply: input fraction plus reciprocal fraction.
   function automatic int round_shift(input int frac);
      return frac + RECIP_FRAC;
   endfunction

endpackage

// File: rtl/dct_quant_mul.sv
// dct_quant_mul: combinational reciprocal-multiply quantizer.
// q = sat(round_half_away(x * recip / 2^(FRAC+16))).
module dct_quant_mul
   import dct_quant_pkg::*;
#(
   parameter int IN_W  = 32,
   parameter int QW    = 17,
   parameter int FRAC  = 15,
   parameter int OUT_W = 12
) (
   input  logic signed [IN_W-1:0]  x,
   input  logic        [QW-1:0]    recip,
   output logic signed [OUT_W-1:0] q
);

   // Product width: signed input times zero-extended (signed) reciprocal.
   localparam int PW = IN_W + QW + 1;
   localparam int S  = round_shift(FRAC);

   localparam logic signed [PW-1:0] HALF    = PW'(1) <<< (S - 1);
   localparam logic signed [PW-1:0] HALF_M1 = HALF - PW'(1);
   localparam logic signed [PW-1:0] MAXV    = PW'((1 <<< (OUT_W - 1)) - 1);
   localparam logic signed [PW-1:0] MINV    = -MAXV - PW'(1);

   logic signed [PW-1:0] x_ext;
   logic signed [PW-1:0] r_ext;
   logic signed [PW-1:0] prod;
   logic signed [PW-1:0] biased;
   logic signed [PW-1:0] shifted;

   // Multiply, bias for round-half-away-from-zero, shift, then clamp.
   always_comb begin
      x_ext   = PW'(x);
      r_ext   = PW'(recip);
      prod    = x_ext * r_ext;
      // Negative products get one less bias so the floor of the shift
      // lands on the away-from-zero value at exact halves.
      biased  = prod + (prod[PW-1] ? HALF_M1 : HALF);
      shifted = biased >>> S;
      if (shifted > MAXV) begin
         q = MAXV[OUT_W-1:0];
      end else if (shifted < MINV) begin
         q = MINV[OUT_W-1:0];
      end else begin
         q = shifted[OUT_W-1:0];
      end
   end

endmodule

// File: rtl/dct_quant_zigzag.sv
// dct_quant_zigzag: buffers one 8x8 DCT block, quantizes each coefficient by
// reciprocal multiply and streams the results in zigzag order, one per cycle.
// Optional macro QTAB_LOAD_EN adds a writable reciprocal table
// (qtab_we/qtab_addr/qtab_wdata); without it the package table is used.
module dct_quant_zigzag
   import dct_quant_pkg::*;
#(
   parameter int IN_W  = 32,
   parameter int FRAC  = 15,
   parameter int OUT_W = 12,
   parameter int QW    = 17
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [64*IN_W-1:0]       in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [OUT_W-1:0]  out_data,
   output logic [5:0]               out_idx,
   output logic                     out_last
`ifdef QTAB_LOAD_EN
   ,
   input  logic                     qtab_we,
   input  logic [5:0]               qtab_addr,
   input  logic [QW-1:0]            qtab_wdata
`endif
);

   state_t                  state_q, state_d;
   logic [5:0]              cnt_q, cnt_d;
   logic                    out_valid_q, out_valid_d;
   logic signed [OUT_W-1:0] out_data_q, out_data_d;
   logic [5:0]              out_idx_q, out_idx_d;
   logic                    out_last_q, out_last_d;

   logic signed [IN_W-1:0]  in_arr [BLK_N];
   logic signed [IN_W-1:0]  blk_q  [BLK_N];
   logic signed [IN_W-1:0]  blk_d  [BLK_N];
   logic [QW-1:0]           recip_tab [BLK_N];

   logic                    load_en;
   logic                    accept;
   logic                    cnt_last;
   logic [5:0]              zz_pos;
   logic signed [IN_W-1:0]  coef_sel;
   logic [QW-1:0]           recip_sel;
   logic signed [OUT_W-1:0] quant_val;

   // Unpack the flat raster bus into per-coefficient words.
   for (genvar gi = 0; gi < BLK_N; gi++) begin : g_unpack
      assign in_arr[gi] = in_data[gi*IN_W +: IN_W];
   end

`ifdef QTAB_LOAD_EN
   logic [QW-1:0] recip_q [BLK_N];
   logic [QW-1:0] recip_d [BLK_N];
   logic          qtab_wr_ok;

   // Table updates only land while idle and not taking a block, so a block
   // is always quantized with one consistent table.
   assign qtab_wr_ok = qtab_we && (state_q == IDLE) && !accept;

   // Next reciprocal table contents.
   always_comb begin
      for (int i = 0; i < BLK_N; i++) begin
         recip_d[i] = recip_q[i];
      end
      if (qtab_wr_ok) begin
         recip_d[qtab_addr] = qtab_wdata;
      end
   end

   // Reciprocal register file, reset to the luminance defaults.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < BLK_N; i++) begin
            recip_q[i] <= QW'(RECIP_LUMA[i]);
         end
      end else begin
         for (int i = 0; i < BLK_N; i++) begin
            recip_q[i] <= recip_d[i];
         end
      end
   end

   for (genvar gi = 0; gi < BLK_N; gi++) begin : g_recip
      assign recip_tab[gi] = recip_q[gi];
   end
`else
   for (genvar gi = 0; gi < BLK_N; gi++) begin : g_recip
      assign recip_tab[gi] = QW'(RECIP_LUMA[gi]);
   end
`endif

   // Handshake terms. The output register may be (re)loaded whenever it is
   // empty or its current beat is being taken; a new block is accepted only
   // when idle or on the very beat that loads the final coefficient, which
   // is what lets blocks stream without bubbles.
   assign cnt_last = (cnt_q == 6'd63);
   assign load_en  = (state_q == RUN) && (!out_valid_q || out_ready);
   assign in_ready = !rst && ((state_q == IDLE) || (cnt_last && load_en));
   assign accept   = in_valid && in_ready;

   // Select the coefficient and reciprocal at the current zigzag position.
   assign zz_pos    = ZZ_ORDER[cnt_q];
   assign coef_sel  = blk_q[zz_pos];
   assign recip_sel = recip_tab[zz_pos];

   dct_quant_mul #(
      .IN_W  (IN_W),
      .QW    (QW),
      .FRAC  (FRAC),
      .OUT_W (OUT_W)
   ) u_mul (
      .x     (coef_sel),
      .recip (recip_sel),
      .q     (quant_val)
   );

   // Block buffer captures the whole block on accept, otherwise holds.
   always_comb begin
      for (int i = 0; i < BLK_N; i++) begin
         blk_d[i] = accept ? in_arr[i] : blk_q[i];
      end
   end

   // Block buffer storage; pure datapath, no reset needed.
   always_ff @(posedge clk) begin
      for (int i = 0; i < BLK_N; i++) begin
         blk_q[i] <= blk_d[i];
      end
   end

   // Control FSM next state plus output-register next values.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_idx_d   = out_idx_q;
      out_last_d  = out_last_q;

      if (load_en) begin
         out_data_d  = quant_val;
         out_idx_d   = cnt_q;
         out_last_d  = cnt_last;
         out_valid_d = 1'b1;
         cnt_d       = cnt_q + 6'd1;
         if (cnt_last) begin
            state_d = IDLE;
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end

      // A fresh block restarts the scan; this overrides the drop to IDLE
      // on the last beat when blocks arrive back to back.
      if (accept) begin
         cnt_d   = 6'd0;
         state_d = RUN;
      end
   end

   // State, counter and output register; reset abandons any block in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= 6'd0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_idx_q   <= 6'd0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_idx_q   <= out_idx_d;
         out_last_q  <= out_last_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_idx   = out_idx_q;
   assign out_last  = out_last_q;

endmodule

// File: tb/tb_dct_quant_zigzag.sv
// tb_dct_quant_zigzag: directed vector table plus hand sequences for
// backpressure, back-to-back streaming and mid-block reset.
`timescale 1ns/1ps
module tb_dct_quant_zigzag;

   localparam int IN_W  = 32;
   localparam int OUT_W = 12;

   logic                    clk = 1'b0;
   logic                    rst = 1'b1;
   logic                    in_valid = 1'b0;
   logic                    in_ready;
   logic [64*IN_W-1:0]      in_data = '0;
   logic                    out_valid;
   logic                    out_ready = 1'b1;
   logic signed [OUT_W-1:0] out_data;
   logic [5:0]              out_idx;
   logic                    out_last;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   dct_quant_zigzag #(
      .IN_W  (IN_W),
      .FRAC  (15),
      .OUT_W (OUT_W),
      .QW    (17)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_last  (out_last)
   );

   // Bench-side reference tables (quant table and zigzag walk built here).
   int qtab [64] = '{
      16,  11,  10,  16,  24,  40,  51,  61,
      12,  12,  14,  19,  26,  58,  60,  55,
      14,  13,  16,  24,  40,  57,  69,  56,
      14,  17,  22,  29,  51,  87,  80,  62,
      18,  22,  37,  56,  68, 109, 103,  77,
      24,  35,  55,  64,  81, 104, 113,  92,
      49,  64,  78,  87, 103, 121, 120, 101,
      72,  92,  95,  98, 112, 100, 103,  99
   };
   int zz [64];

   typedef struct {
      logic signed [OUT_W-1:0] data;
      int                      idx;
      logic                    last;
      int                      cyc;
   } beat_t;

   typedef struct {
      string              name;
      int                 pos_a;
      logic signed [31:0] val_a;
      int                 pos_b;
      logic signed [31:0] val_b;
      int                 idx_a;
      int                 exp_a;
      int                 idx_b;
      int                 exp_b;
   } vec_t;

   beat_t              beats [$];
   int                 exp_seq [$];
   int                 rdy_log [$];
   logic [64*IN_W-1:0] pend [$];
   vec_t               vecs [$];

   task automatic check(input string nm, input logic signed [63:0] act,
                        input logic signed [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", nm, act, exp);
      end
   endtask

   function automatic int ref_quant(input logic signed [31:0] x, input int q);
      longint recip, num, mag, r;
      recip = (65536 + q / 2) / q;
      num   = longint'(x) * recip;
      mag   = (num < 0) ? -num : num;
      r     = (mag + 64'sd1073741824) / 64'sd2147483648;
      if (num < 0) r = -r;
      if (r > 2047) r = 2047;
      if (r < -2048) r = -2048;
      return int'(r);
   endfunction

   task automatic build_zz();
      int k, lo, hi;
      k = 0;
      for (int s = 0; s < 15; s++) begin
         lo = (s > 7) ? s - 7 : 0;
         hi = (s < 7) ? s : 7;
         if (s % 2 == 0) begin
            for (int r = hi; r >= lo; r--) begin zz[k] = r * 8 + (s - r); k++; end
         end else begin
            for (int r = lo; r <= hi; r++) begin zz[k] = r * 8 + (s - r); k++; end
         end
      end
   endtask

   task automatic model_block(input logic [64*IN_W-1:0] b);
      logic signed [31:0] x;
      for (int k = 0; k < 64; k++) begin
         x = b[zz[k]*IN_W +: IN_W];
         exp_seq.push_back(ref_quant(x, qtab[zz[k]]));
      end
   endtask

   task automatic rand_block(output logic [64*IN_W-1:0] b);
      int v;
      for (int r = 0; r < 64; r++) begin
         v = int'($urandom_range(19660800)) - 9830400;
         b[r*IN_W +: IN_W] = v;
      end
   endtask

   task automatic add_vec(input string nm, input int pa, input logic signed [31:0] va,
                          input int pb, input logic signed [31:0] vb,
                          input int ia, input int ea, input int ib, input int eb);
      vec_t v;
      v.name = nm; v.pos_a = pa; v.val_a = va; v.pos_b = pb; v.val_b = vb;
      v.idx_a = ia; v.exp_a = ea; v.idx_b = ib; v.exp_b = eb;
      vecs.push_back(v);
   endtask

   // Offers the pending blocks and collects output beats; entered and left
   // just after a rising edge. Checks held outputs on every stalled beat.
   task automatic run_stream(input int nblk, input bit toggle, input int max_cyc);
      int cyc, acc;
      bit prev_stall;
      logic signed [OUT_W-1:0] pd;
      logic [5:0] pi;
      logic pl;
      beat_t bt;
      beats.delete();
      rdy_log.delete();
      cyc = 0; acc = 0; prev_stall = 0; pd = '0; pi = '0; pl = 1'b0;
      in_valid  = (acc < nblk);
      in_data   = pend[0];
      out_ready = 1'b1;
      while (beats.size() < 64 * nblk && cyc < max_cyc) begin
         @(negedge clk);
         rdy_log.push_back(int'(in_ready));
         if (prev_stall) begin
            check("stall_valid", out_valid, 1);
            check("stall_data", out_data, pd);
            check("stall_idx", out_idx, pi);
            check("stall_last", out_last, pl);
         end
         prev_stall = out_valid && !out_ready;
         pd = out_data; pi = out_idx; pl = out_last;
         if (out_valid && out_ready) begin
            bt.data = out_data; bt.idx = int'(out_idx); bt.last = out_last; bt.cyc = cyc;
            beats.push_back(bt);
         end
         if (in_valid && in_ready) acc++;
         @(posedge clk);
         #1;
         cyc++;
         in_valid = (acc < nblk);
         if (acc < nblk) in_data = pend[acc];
         out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
   endtask

   task automatic verify(input string nm, input bit timing);
      check({nm, "_beats"}, beats.size(), exp_seq.size());
      for (int k = 0; k < beats.size() && k < exp_seq.size(); k++) begin
         check({nm, "_idx"}, beats[k].idx, k % 64);
         check({nm, "_last"}, beats[k].last, (k % 64 == 63));
         check({nm, "_data"}, beats[k].data, exp_seq[k]);
         if (timing) check({nm, "_cycle"}, beats[k].cyc, 2 + k);
      end
   endtask

   task automatic drain_check(input string nm);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check({nm, "_drain_valid"}, out_valid, 0);
      end
      check({nm, "_idle_ready"}, in_ready, 1);
      @(posedge clk);
      #1;
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      logic [64*IN_W-1:0] blk, blk2;
      int e, ones;
      bit found;

      build_zz();

      add_vec("dc",      0, 800 * 32768,  -1, 0,           0, 50,    -1, 0);
      add_vec("zigzag",  1, 33 * 32768,    8, 60 * 32768,  1, 3,      2, 5);
      add_vec("rnd_pos", 0, 24 * 32768,   -1, 0,           0, 2,     -1, 0);
      add_vec("rnd_neg", 0, -(24 * 32768), -1, 0,          0, -2,    -1, 0);
      add_vec("half_up", 0, 8 * 32768,    -1, 0,           0, 1,     -1, 0);
      add_vec("half_dn", 0, -(8 * 32768), -1, 0,           0, -1,    -1, 0);
      add_vec("to_zero", 0, -(7 * 32768), -1, 0,           0, 0,     -1, 0);
      add_vec("sat_pos", 0, 32'sh7FFFFFFF, -1, 0,          0, 2047,  -1, 0);
      add_vec("sat_neg", 0, 32'sh80000000, -1, 0,          0, -2048, -1, 0);
      add_vec("pos63",  63, 693 * 32768,  -1, 0,          63, 7,     -1, 0);

      // Reset state
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_out_valid", out_valid, 0);
      check("reset_in_ready", in_ready, 0);
      check("reset_out_data", out_data, 0);
      check("reset_out_idx", out_idx, 0);
      check("reset_out_last", out_last, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("release_in_ready", in_ready, 1);
      @(posedge clk);
      #1;

      // Directed single-block vectors
      for (int v = 0; v < vecs.size(); v++) begin
         blk = '0;
         blk[vecs[v].pos_a*IN_W +: IN_W] = vecs[v].val_a;
         if (vecs[v].pos_b >= 0) blk[vecs[v].pos_b*IN_W +: IN_W] = vecs[v].val_b;
         pend.delete();
         pend.push_back(blk);
         exp_seq.delete();
         for (int k = 0; k < 64; k++) begin
            e = 0;
            if (k == vecs[v].idx_a) e = vecs[v].exp_a;
            if (k == vecs[v].idx_b) e = vecs[v].exp_b;
            exp_seq.push_back(e);
         end
         run_stream(1, 1'b0, 300);
         verify(vecs[v].name, 1'b1);
         if (v == 0 && rdy_log.size() > 64) begin
            ones = 0;
            for (int c = 1; c < 64; c++) ones += rdy_log[c];
            check("dc_in_ready_busy", ones, 0);
            check("dc_in_ready_last", rdy_log[64], 1);
         end
         $display("vector %s: %0d beats", vecs[v].name, beats.size());
         drain_check(vecs[v].name);
      end

      // Backpressure: out_ready toggling 1,0,1,0
      rand_block(blk);
      blk[0 +: IN_W] = 32'sh7FFFFFFF;
      pend.delete();
      pend.push_back(blk);
      exp_seq.delete();
      model_block(blk);
      run_stream(1, 1'b1, 400);
      verify("bp", 1'b0);
      $display("backpressure: %0d beats", beats.size());
      drain_check("bp");

      // Two blocks back to back, no bubbles
      rand_block(blk);
      rand_block(blk2);
      blk2[63*IN_W +: IN_W] = 32'sh80000000;
      pend.delete();
      pend.push_back(blk);
      pend.push_back(blk2);
      exp_seq.delete();
      model_block(blk);
      model_block(blk2);
      run_stream(2, 1'b0, 400);
      verify("b2b", 1'b1);
      $display("back-to-back: %0d beats", beats.size());
      drain_check("b2b");

      // Reset in the middle of a block
      rand_block(blk);
      in_data  = blk;
      in_valid = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 100 && !found; c++) begin
         @(negedge clk);
         if (out_valid && out_idx == 6'd20) begin
            found = 1'b1;
         end else begin
            @(posedge clk);
            #1;
         end
      end
      check("rst_reached_idx20", found, 1);
      rst = 1'b1;
      #1;
      check("rst_in_ready_comb", in_ready, 0);
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_idx", out_idx, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_release_ready", in_ready, 1);
      check("rst_release_valid", out_valid, 0);
      repeat (2) begin
         @(negedge clk);
         check("rst_no_resume", out_valid, 0);
      end
      @(posedge clk);
      #1;
      rand_block(blk);
      pend.delete();
      pend.push_back(blk);
      exp_seq.delete();
      model_block(blk);
      run_stream(1, 1'b0, 300);
      verify("after_rst", 1'b1);
      $display("after reset: %0d beats", beats.size());
      drain_check("after_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
